frame_reader: RTL and testbench
===============================

Name: frame_reader

Overview:
- Read-side scanner for the dual-port frame buffer: on a start pulse, walks port B addresses 0..WIDTH*HEIGHT-1 in raster order.
- Converts the buffer's one-cycle registered-address read into an AXI4-Stream video pixel stream with full backpressure support.
- Sits directly downstream of the frame buffer, driving its enb/addrb and consuming dob; feeds the display/processing pipeline.

Parameters:
- WIDTH, 640, pixels per line.
- HEIGHT, 480, lines per frame.
- BIT_WIDTH, 8, pixel data width (matches the frame buffer).

Ports:
- clk  in  1  system clock, all logic on posedge.
- rst  in  1  synchronous active-high reset.
- start  in  1  one-cycle pulse: begin reading one frame; ignored while busy=1.
- busy  out  1  high from the cycle after an accepted start until the last pixel handshake completes.
- frame_done  out  1  one-cycle pulse in the cycle after the last pixel (tlast on the final line) handshakes.
- bram_en  out  1  to frame buffer enb.
- bram_addr  out  $clog2(WIDTH*HEIGHT)+1  to frame buffer addrb.
- bram_dout  in  BIT_WIDTH  from frame buffer dob; valid the cycle after bram_en=1.
- m_axis_tdata  out  BIT_WIDTH  pixel.
- m_axis_tvalid  out  1  pixel valid.
- m_axis_tready  in  1  downstream ready.
- m_axis_tuser  out  1  start of frame; high on pixel (0,0) only.
- m_axis_tlast  out  1  end of line; high on x=WIDTH-1 of every line.

Behaviour:
- Reset: busy=0, frame_done=0, bram_en=0, bram_addr=0, m_axis_tvalid=0, tdata/tuser/tlast=0. Counters, FIFO and in-flight flag are cleared. Reset mid-frame aborts the frame with no frame_done; any buffered pixels are discarded.
- FSM states:
  - IDLE: start=1 goes to RUN, clearing read address, x and y counters.
  - RUN: issues reads; after the read of address WIDTH*HEIGHT-1 is issued, goes to DRAIN.
  - DRAIN: waits for FIFO empty and no read in flight; then pulses frame_done and goes to IDLE.
  - start outside IDLE has no effect.
- Read issue:
  - Condition: bram_en=1 iff state=RUN and (fifo_count + inflight - pop) < 2, where pop = m_axis_tvalid & m_axis_tready.
  - bram_addr holds the issue address. It increments by 1 after each issue and is never driven past WIDTH*HEIGHT-1.
  - inflight register is set to the value of bram_en for the next cycle.
- Capture: when inflight=1, bram_dout is written into a 2-entry output FIFO, tagged with the tuser/tlast computed from the issue-time x/y counters (pipelined one cycle alongside inflight).
- x/y counters advance per issue:
  - x wraps WIDTH-1 → 0 and then y increments.
  - y=HEIGHT-1 with x=WIDTH-1 is the final issue.
- Output:
  - m_axis_* present the FIFO head; tvalid = fifo_count != 0.
  - Once tvalid=1, data/tuser/tlast hold stable until the handshake (AXI rule).
  - Simultaneous push and pop keeps the count unchanged. The credit rule guarantees the FIFO never overflows.
- Throughput: with tready held 1, one pixel per cycle sustained. First tvalid appears 2 cycles after the start pulse (issue at cycle +1, capture at cycle +2).
- Backpressure: tready=0 stalls issue within one cycle. No pixel is lost or duplicated; the sequence is identical to the no-stall case.
- bram_en=0 leaves the frame buffer read address unchanged, so dob is stable; the reader never depends on this beyond the capture cycle.
- Arithmetic: bram_addr = linear counter (not y*WIDTH+x); x/y are used only for tags. x width $clog2(WIDTH), y width $clog2(HEIGHT), minimum 1 bit.
- busy=1 in RUN and DRAIN.

Test Plan (WIDTH=4, HEIGHT=3, frame buffer preloaded mem[i]=i+16):
- Reset then start, tready=1 → bram_addr 0..11 on consecutive cycles; tdata 16..27 on 12 consecutive cycles starting 2 cycles after start; tuser only on 16; tlast on 19, 23, 27; frame_done pulses the cycle after 27 handshakes; busy falls with it.
- tready toggles 1,0,1,0… → still exactly 12 beats, values 16..27 in order; tdata stable while tvalid=1 and tready=0; fifo_count never exceeds 2.
- tready=0 for 10 cycles after start → at most 2 reads issued; tvalid=1 with tdata=16 held; releasing tready completes the frame normally.
- Second start pulse at pixel 5 → ignored; frame completes with 12 beats; a new start after frame_done produces an identical frame.
- rst asserted at pixel 6 → next cycle tvalid=0, busy=0, bram_en=0; no frame_done; a subsequent start begins again at addr 0 with tuser on 16.
- start coincident with rst → reset wins, state stays IDLE.

Source files
------------

// File: rtl/frame_reader.sv
// rtl/frame_reader.sv - raster-order frame buffer scanner producing an AXI4-Stream video pixel stream
module frame_reader #(
    parameter int WIDTH     = 640,
    parameter int HEIGHT    = 480,
    parameter int BIT_WIDTH = 8
) (
    input  logic                                clk,
    input  logic                                rst,
    input  logic                                start,
    output logic                                busy,
    output logic                                frame_done,
    output logic                                bram_en,
    output logic [$clog2(WIDTH*HEIGHT):0]       bram_addr,
    input  logic [BIT_WIDTH-1:0]                bram_dout,
    output logic [BIT_WIDTH-1:0]                m_axis_tdata,
    output logic                                m_axis_tvalid,
    input  logic                                m_axis_tready,
    output logic                                m_axis_tuser,
    output logic                                m_axis_tlast
);

    localparam int NPIX = WIDTH * HEIGHT;
    localparam int AW   = $clog2(NPIX) + 1;
    localparam int XW   = (WIDTH  > 1) ? $clog2(WIDTH)  : 1;
    localparam int YW   = (HEIGHT > 1) ? $clog2(HEIGHT) : 1;

    localparam logic [AW-1:0] LAST_ADDR = AW'(NPIX - 1);
    localparam logic [XW-1:0] X_LAST    = XW'(WIDTH - 1);
    localparam logic [YW-1:0] Y_LAST    = YW'(HEIGHT - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_DRAIN
    } state_t;

    state_t              state_q, state_d;
    logic [AW-1:0]       addr_q, addr_d;
    logic [XW-1:0]       x_q, x_d;
    logic [YW-1:0]       y_q, y_d;
    logic                frame_done_q, frame_done_d;
    logic                inflight_q;
    logic                tag_user_q, tag_last_q;

    // Two-entry output FIFO: one slot covers the read in flight, the other the stalled head.
    logic [BIT_WIDTH-1:0] fifo_data_q [2];
    logic                 fifo_user_q [2];
    logic                 fifo_last_q [2];
    logic                 wr_ptr_q, rd_ptr_q;
    logic [1:0]           count_q;

    logic                 issue;
    logic                 push;
    logic                 pop;
    logic [2:0]           pending;
    logic [1:0]           count_next;

    assign m_axis_tvalid = (count_q != 2'd0);
    assign pop           = m_axis_tvalid & m_axis_tready;
    assign push          = inflight_q;
    // Occupancy the FIFO will hold once this cycle's pop retires, counting the read already in flight.
    assign pending       = {1'b0, count_q} + {2'b00, inflight_q} - {2'b00, pop};
    assign issue         = (state_q == S_RUN) && (pending < 3'd2);
    assign count_next    = count_q + {1'b0, push} - {1'b0, pop};

    assign bram_en       = issue;
    assign bram_addr     = addr_q;
    assign busy          = (state_q != S_IDLE);
    assign frame_done    = frame_done_q;
    assign m_axis_tdata  = m_axis_tvalid ? fifo_data_q[rd_ptr_q] : '0;
    assign m_axis_tuser  = m_axis_tvalid ? fifo_user_q[rd_ptr_q] : 1'b0;
    assign m_axis_tlast  = m_axis_tvalid ? fifo_last_q[rd_ptr_q] : 1'b0;

    // Next-state logic: frame sequencing, read address and raster x/y tags.
    always_comb begin
        state_d      = state_q;
        addr_d       = addr_q;
        x_d          = x_q;
        y_d          = y_q;
        frame_done_d = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d = S_RUN;
                    addr_d  = '0;
                    x_d     = '0;
                    y_d     = '0;
                end
            end
            S_RUN: begin
                if (issue) begin
                    if (addr_q == LAST_ADDR) begin
                        state_d = S_DRAIN;
                    end else begin
                        addr_d = addr_q + 1'b1;
                    end
                    if (x_q == X_LAST) begin
                        x_d = '0;
                        y_d = (y_q == Y_LAST) ? '0 : y_q + 1'b1;
                    end else begin
                        x_d = x_q + 1'b1;
                    end
                end
            end
            S_DRAIN: begin
                // Leave DRAIN on the edge that retires the last pixel so busy and frame_done switch together.
                if (count_next == 2'd0) begin
                    state_d      = S_IDLE;
                    frame_done_d = 1'b1;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // State, counters, read pipeline and FIFO storage.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q        <= S_IDLE;
            addr_q         <= '0;
            x_q            <= '0;
            y_q            <= '0;
            frame_done_q   <= 1'b0;
            inflight_q     <= 1'b0;
            tag_user_q     <= 1'b0;
            tag_last_q     <= 1'b0;
            wr_ptr_q       <= 1'b0;
            rd_ptr_q       <= 1'b0;
            count_q        <= 2'd0;
            fifo_data_q[0] <= '0;
            fifo_data_q[1] <= '0;
            fifo_user_q[0] <= 1'b0;
            fifo_user_q[1] <= 1'b0;
            fifo_last_q[0] <= 1'b0;
            fifo_last_q[1] <= 1'b0;
        end else begin
            state_q      <= state_d;
            addr_q       <= addr_d;
            x_q          <= x_d;
            y_q          <= y_d;
            frame_done_q <= frame_done_d;
            inflight_q   <= issue;
            count_q      <= count_next;
            if (issue) begin
                tag_user_q <= (x_q == '0) && (y_q == '0);
                tag_last_q <= (x_q == X_LAST);
            end
            if (push) begin
                fifo_data_q[wr_ptr_q] <= bram_dout;
                fifo_user_q[wr_ptr_q] <= tag_user_q;
                fifo_last_q[wr_ptr_q] <= tag_last_q;
                wr_ptr_q              <= ~wr_ptr_q;
            end
            if (pop) begin
                rd_ptr_q <= ~rd_ptr_q;
            end
        end
    end

endmodule

// File: tb/tb_frame_reader.sv
// tb/tb_frame_reader.sv - scoreboard testbench for frame_reader
module tb_frame_reader;

    localparam int W  = 4;
    localparam int H  = 3;
    localparam int N  = W * H;
    localparam int BW = 8;
    localparam int AW = $clog2(N) + 1;

    typedef struct packed {
        logic [BW-1:0] d;
        logic          u;
        logic          l;
    } beat_t;

    logic          clk = 1'b0;
    logic          rst;
    logic          start;
    logic          busy;
    logic          frame_done;
    logic          bram_en;
    logic [AW-1:0] bram_addr;
    logic [BW-1:0] bram_dout = '0;
    logic [BW-1:0] tdata;
    logic          tvalid;
    logic          tready;
    logic          tuser;
    logic          tlast;

    int    checks   = 0;
    int    failures = 0;
    beat_t exp_q[$];

    int    cyc = 0;
    int    beats = 0;
    int    first_cyc = 0;
    int    done_cyc = 0;
    int    done_cnt = 0;
    int    issue_cnt = 0;
    int    outstanding = 0;
    int    max_out = 0;
    logic  expect_done = 1'b0;
    logic  stall = 1'b0;
    beat_t stall_beat;
    int    tmode = 0;

    logic [BW-1:0] mem [N];

    frame_reader #(.WIDTH(W), .HEIGHT(H), .BIT_WIDTH(BW)) dut (
        .clk           (clk),
        .rst           (rst),
        .start         (start),
        .busy          (busy),
        .frame_done    (frame_done),
        .bram_en       (bram_en),
        .bram_addr     (bram_addr),
        .bram_dout     (bram_dout),
        .m_axis_tdata  (tdata),
        .m_axis_tvalid (tvalid),
        .m_axis_tready (tready),
        .m_axis_tuser  (tuser),
        .m_axis_tlast  (tlast)
    );

    always #5 clk = ~clk;

    initial begin
        for (int i = 0; i < N; i++) mem[i] = BW'(i + 16);
    end

    // Frame buffer port B: registered read, output held while enb is low.
    always @(posedge clk) begin
        if (bram_en) bram_dout <= mem[int'(bram_addr) % N];
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push_frame();
        beat_t b;
        for (int i = 0; i < N; i++) begin
            b.d = BW'(i + 16);
            b.u = (i == 0);
            b.l = ((i % W) == W - 1);
            exp_q.push_back(b);
        end
    endtask

    task automatic pulse_start(input logic expect_accept);
        start = 1'b1;
        if (expect_accept) push_frame();
        tick();
        start = 1'b0;
    endtask

    task automatic wait_done(input int budget);
        int d0;
        d0 = done_cnt;
        for (int i = 0; i < budget; i++) begin
            if (done_cnt != d0) break;
            tick();
        end
        check("frame_done_seen", 32'(done_cnt - d0), 32'd1);
    endtask

    task automatic wait_beats(input int n, input int budget);
        for (int i = 0; i < budget; i++) begin
            if (beats >= n) break;
            tick();
        end
        check("beats_reached", 32'(beats >= n), 32'd1);
    endtask

    // tready driver: 0 = always ready, 1 = toggling, 2 = held low.
    initial begin
        tready = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            if (tmode == 1)      tready = ~tready;
            else if (tmode == 2) tready = 1'b0;
            else                 tready = 1'b1;
        end
    end

    // Monitor: sampled on the falling edge, pops the scoreboard on every handshake.
    always @(negedge clk) begin
        beat_t e;
        beat_t act;
        cyc++;
        act = {tdata, tuser, tlast};
        if (rst) begin
            expect_done = 1'b0;
            stall       = 1'b0;
            outstanding = 0;
        end else begin
            if (expect_done || frame_done) begin
                check("frame_done", 32'(frame_done), 32'(expect_done));
                if (expect_done) check("busy_low_at_done", 32'(busy), 32'd0);
                if (frame_done) begin
                    done_cnt++;
                    done_cyc = cyc;
                end
            end
            expect_done = 1'b0;
            if (stall) begin
                check("hold_tvalid", 32'(tvalid), 32'd1);
                check("hold_beat", 32'(act), 32'(stall_beat));
            end
            if (tvalid && tready) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL spurious_beat actual=%0h required=none", act);
                end else begin
                    e = exp_q.pop_front();
                    check("beat", 32'(act), 32'(e));
                    beats++;
                    if (beats == 1) first_cyc = cyc;
                    if (exp_q.size() == 0) expect_done = 1'b1;
                end
            end
            stall       = tvalid && !tready;
            stall_beat  = act;
            issue_cnt   = issue_cnt + int'(bram_en);
            outstanding = outstanding + int'(bram_en) - int'(tvalid && tready);
            if (outstanding > max_out) max_out = outstanding;
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int i0;
        int d0;
        rst   = 1'b1;
        start = 1'b0;
        repeat (3) tick();
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_frame_done", 32'(frame_done), 32'd0);
        check("rst_bram_en", 32'(bram_en), 32'd0);
        check("rst_bram_addr", 32'(bram_addr), 32'd0);
        check("rst_tvalid", 32'(tvalid), 32'd0);
        check("rst_tags_data", 32'({tdata, tuser, tlast}), 32'd0);
        rst = 1'b0;
        tick();

        // Full-rate frame: consecutive addresses, first beat two edges after start.
        tmode   = 0;
        beats   = 0;
        max_out = 0;
        pulse_start(1'b1);
        for (int k = 0; k < N; k++) begin
            check("t1_bram_en", 32'(bram_en), 32'd1);
            check("t1_bram_addr", 32'(bram_addr), 32'(k));
            if (k == 1) check("t1_tvalid_early", 32'(tvalid), 32'd0);
            if (k == 2) check("t1_tvalid_first", 32'(tvalid), 32'd1);
            tick();
        end
        check("t1_bram_en_after", 32'(bram_en), 32'd0);
        wait_done(40);
        check("t1_beats", 32'(beats), 32'(N));
        check("t1_consecutive", 32'(done_cyc - first_cyc), 32'(N));
        check("t1_busy_idle", 32'(busy), 32'd0);
        check("t1_max_outstanding", 32'(max_out <= 2), 32'd1);

        // Alternating backpressure.
        tmode   = 1;
        beats   = 0;
        max_out = 0;
        pulse_start(1'b1);
        wait_done(100);
        check("t2_beats", 32'(beats), 32'(N));
        check("t2_max_outstanding", 32'(max_out <= 2), 32'd1);

        // Downstream stalled for ten cycles after start.
        tmode = 2;
        tick();
        tick();
        beats = 0;
        i0    = issue_cnt;
        pulse_start(1'b1);
        repeat (10) tick();
        check("t3_issues", 32'(issue_cnt - i0 <= 2), 32'd1);
        check("t3_tvalid", 32'(tvalid), 32'd1);
        check("t3_tdata", 32'(tdata), 32'd16);
        check("t3_tuser", 32'(tuser), 32'd1);
        tmode = 0;
        wait_done(60);
        check("t3_beats", 32'(beats), 32'(N));

        // Start while busy is ignored; a later start repeats the frame.
        beats = 0;
        pulse_start(1'b1);
        wait_beats(5, 40);
        pulse_start(1'b0);
        wait_done(40);
        check("t4_beats", 32'(beats), 32'(N));
        beats = 0;
        pulse_start(1'b1);
        wait_done(40);
        check("t4_beats_again", 32'(beats), 32'(N));

        // Reset mid-frame aborts without frame_done.
        tmode = 1;
        beats = 0;
        pulse_start(1'b1);
        wait_beats(6, 60);
        rst = 1'b1;
        tick();
        check("t5_tvalid", 32'(tvalid), 32'd0);
        check("t5_busy", 32'(busy), 32'd0);
        check("t5_bram_en", 32'(bram_en), 32'd0);
        exp_q.delete();
        rst  = 1'b0;
        d0   = done_cnt;
        repeat (20) tick();
        check("t5_no_done", 32'(done_cnt - d0), 32'd0);
        check("t5_idle_tvalid", 32'(tvalid), 32'd0);
        tmode = 0;
        beats = 0;
        pulse_start(1'b1);
        check("t5_restart_en", 32'(bram_en), 32'd1);
        check("t5_restart_addr", 32'(bram_addr), 32'd0);
        wait_done(40);
        check("t5_beats", 32'(beats), 32'(N));

        // Start coincident with reset: reset wins.
        rst   = 1'b1;
        start = 1'b1;
        tick();
        rst   = 1'b0;
        start = 1'b0;
        tick();
        tick();
        check("t6_busy", 32'(busy), 32'd0);
        check("t6_bram_en", 32'(bram_en), 32'd0);
        check("t6_tvalid", 32'(tvalid), 32'd0);
        check("t6_queue_empty", 32'(exp_q.size()), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
